dce_loopback_fifo: RTL and testbench

Parametrised, synthesizable DCE loopback endpoint for the UART test harness. Deserialises characters arriving on `rxd` from the DTE transactor, buffers them in a receive FIFO, optionally upper-cases them, and reserialises them on `txd`. Generalises the fixed 8-bit behavioural loopback:
- configurable character width, stop bits, divisor and buffer depth;
- real RTS/CTS hardware flow control;
- framing and overrun error reporting.

---
 rtl/dce_loopback_fifo.sv | 319 +++++++++++++++++++++++++++++++
 tb/tb_dce_loopback_fifo.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dce_loopback_fifo.sv
// UART DCE loopback: synced rxd -> receiver -> circular FIFO -> optional upcase -> transmitter, RTS/CTS flow control.
// Push 1 clk after stop sample, txd start 1 clk after pop; full FIFO drops with overrun_err; define DCE_LOOPBACK_PARITY_EN for even parity.
module dce_loopback_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int DIVISOR    = 80,
  parameter int FIFO_DEPTH = 8,
  parameter int RTS_MARGIN = 2
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          cts,
  input  logic                          rxd,
  input  logic                          upcase_en,
  output logic                          rts,
  output logic                          txd,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          frame_err,
  output logic                          overrun_err
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(STOP_BITS * DIVISOR + 1);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] DIV_C    = CW'(DIVISOR);
  localparam logic [CW-1:0] HALF_C   = CW'(DIVISOR / 2);
  localparam logic [CW-1:0] STOP_C   = CW'(STOP_BITS * DIVISOR);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] BIT_ONE  = BW'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   FULL_LVL = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]   RTS_THR  = (AW+1)'(FIFO_DEPTH - RTS_MARGIN);

`ifdef DCE_LOOPBACK_PARITY_EN
  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_PARITY, R_STOP} rx_state_t;
  typedef enum logic [2:0] {T_IDLE, T_START, T_DATA, T_PARITY, T_STOP} tx_state_t;
`else
  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
  typedef enum logic [2:0] {T_IDLE, T_START, T_DATA, T_STOP} tx_state_t;
`endif

  logic [1:0] rxd_sync_q, cts_sync_q;
  logic       rxd_s, cts_s;

  rx_state_t            rx_state_q, rx_state_d;
  logic [CW-1:0]        rx_cnt_q, rx_cnt_d;
  logic [BW-1:0]        rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
  logic                 rx_wait_q, rx_wait_d;
  logic                 rx_push_q, rx_push_d;
  logic                 rx_ferr_q, rx_ferr_d;
`ifdef DCE_LOOPBACK_PARITY_EN
  logic                 rx_perr_q, rx_perr_d;
  logic                 tx_par_q, tx_par_d;
`endif

  tx_state_t            tx_state_q, tx_state_d;
  logic [CW-1:0]        tx_cnt_q, tx_cnt_d;
  logic [BW-1:0]        tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic                 txd_q, txd_d;
  logic                 rts_q;

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [AW:0]          level_q, level_d;
  logic                 fifo_full, fifo_empty, push, pop, tx_go;
  logic [DATA_BITS-1:0] head, tx_char;
  logic [7:0]           head8;
  logic                 rx_expire, tx_expire;

  assign rxd_s = rxd_sync_q[1];
  assign cts_s = cts_sync_q[1];

  // Receiver
  assign rx_expire = (rx_cnt_q == CNT_ONE);

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_wait_d  = rx_wait_q;
    rx_push_d  = 1'b0;
    rx_ferr_d  = 1'b0;
`ifdef DCE_LOOPBACK_PARITY_EN
    rx_perr_d  = rx_perr_q;
`endif
    if (rx_state_q != R_IDLE) rx_cnt_d = rx_cnt_q - CNT_ONE;
    case (rx_state_q)
      R_IDLE: begin
        // After a framing error the line may still be low; wait for it to recover.
        if (rx_wait_q) begin
          if (rxd_s) rx_wait_d = 1'b0;
        end else if (!rxd_s) begin
          rx_cnt_d   = HALF_C;
          rx_state_d = R_START;
        end
      end
      R_START: begin
        if (rx_expire) begin
          if (rxd_s) begin
            rx_state_d = R_IDLE;
          end else begin
            rx_cnt_d   = DIV_C;
            rx_bit_d   = '0;
            rx_state_d = R_DATA;
          end
        end
      end
      R_DATA: begin
        if (rx_expire) begin
          rx_shift_d = {rxd_s, rx_shift_q[DATA_BITS-1:1]};
          rx_cnt_d   = DIV_C;
          if (rx_bit_q == LAST_BIT) begin
`ifdef DCE_LOOPBACK_PARITY_EN
            rx_state_d = R_PARITY;
`else
            rx_state_d = R_STOP;
`endif
          end else begin
            rx_bit_d = rx_bit_q + BIT_ONE;
          end
        end
      end
`ifdef DCE_LOOPBACK_PARITY_EN
      R_PARITY: begin
        if (rx_expire) begin
          rx_perr_d  = rxd_s ^ (^rx_shift_q);
          rx_cnt_d   = DIV_C;
          rx_state_d = R_STOP;
        end
      end
`endif
      R_STOP: begin
        if (rx_expire) begin
          rx_state_d = R_IDLE;
`ifdef DCE_LOOPBACK_PARITY_EN
          if (!rxd_s || rx_perr_q) begin
`else
          if (!rxd_s) begin
`endif
            rx_ferr_d = 1'b1;
            rx_wait_d = !rxd_s;
          end else begin
            rx_push_d = 1'b1;
          end
        end
      end
      default: rx_state_d = R_IDLE;
    endcase
  end

  // FIFO
  assign fifo_full   = (level_q == FULL_LVL);
  assign fifo_empty  = (level_q == '0);
  assign push        = rx_push_q & (~fifo_full | pop);
  assign overrun_err = rx_push_q & fifo_full & ~pop;
  assign head        = mem_q[rd_ptr_q];

  always_comb begin
    level_d = level_q;
    if (push && !pop)      level_d = level_q + LVL_ONE;
    else if (pop && !push) level_d = level_q - LVL_ONE;
  end

  always_comb begin
    head8   = 8'(head);
    tx_char = head;
    if (upcase_en && (DATA_BITS == 8) && (head8 >= 8'h61) && (head8 <= 8'h7A))
      tx_char = DATA_BITS'(head8 - 8'h20);
  end

  // Transmitter; a new character may also start straight out of the last stop-bit cycle.
  assign tx_expire = (tx_cnt_q == CNT_ONE);
  assign tx_go     = ~fifo_empty & ~cts_s;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    txd_d      = txd_q;
    pop        = 1'b0;
`ifdef DCE_LOOPBACK_PARITY_EN
    tx_par_d   = tx_par_q;
`endif
    if (tx_state_q != T_IDLE) tx_cnt_d = tx_cnt_q - CNT_ONE;
    case (tx_state_q)
      T_IDLE: begin
        txd_d = 1'b1;
        if (tx_go) begin
          pop        = 1'b1;
          tx_shift_d = tx_char;
          txd_d      = 1'b0;
          tx_cnt_d   = DIV_C;
          tx_state_d = T_START;
`ifdef DCE_LOOPBACK_PARITY_EN
          tx_par_d   = ^tx_char;
`endif
        end
      end
      T_START: begin
        if (tx_expire) begin
          txd_d      = tx_shift_q[0];
          tx_cnt_d   = DIV_C;
          tx_bit_d   = '0;
          tx_state_d = T_DATA;
        end
      end
      T_DATA: begin
        if (tx_expire) begin
          tx_cnt_d = DIV_C;
          if (tx_bit_q == LAST_BIT) begin
`ifdef DCE_LOOPBACK_PARITY_EN
            txd_d      = tx_par_q;
            tx_state_d = T_PARITY;
`else
            txd_d      = 1'b1;
            tx_cnt_d   = STOP_C;
            tx_state_d = T_STOP;
`endif
          end else begin
            tx_shift_d = {1'b0, tx_shift_q[DATA_BITS-1:1]};
            txd_d      = tx_shift_q[1];
            tx_bit_d   = tx_bit_q + BIT_ONE;
          end
        end
      end
`ifdef DCE_LOOPBACK_PARITY_EN
      T_PARITY: begin
        if (tx_expire) begin
          txd_d      = 1'b1;
          tx_cnt_d   = STOP_C;
          tx_state_d = T_STOP;
        end
      end
`endif
      T_STOP: begin
        if (tx_expire) begin
          if (tx_go) begin
            pop        = 1'b1;
            tx_shift_d = tx_char;
            txd_d      = 1'b0;
            tx_cnt_d   = DIV_C;
            tx_state_d = T_START;
`ifdef DCE_LOOPBACK_PARITY_EN
            tx_par_d   = ^tx_char;
`endif
          end else begin
            tx_state_d = T_IDLE;
          end
        end
      end
      default: tx_state_d = T_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rxd_sync_q <= 2'b11;
      cts_sync_q <= 2'b11;
      rx_state_q <= R_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_wait_q  <= 1'b0;
      rx_push_q  <= 1'b0;
      rx_ferr_q  <= 1'b0;
`ifdef DCE_LOOPBACK_PARITY_EN
      rx_perr_q  <= 1'b0;
      tx_par_q   <= 1'b0;
`endif
      tx_state_q <= T_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      txd_q      <= 1'b1;
      rts_q      <= 1'b1;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
    end else begin
      rxd_sync_q <= {rxd_sync_q[0], rxd};
      cts_sync_q <= {cts_sync_q[0], cts};
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_wait_q  <= rx_wait_d;
      rx_push_q  <= rx_push_d;
      rx_ferr_q  <= rx_ferr_d;
`ifdef DCE_LOOPBACK_PARITY_EN
      rx_perr_q  <= rx_perr_d;
      tx_par_q   <= tx_par_d;
`endif
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      txd_q      <= txd_d;
      rts_q      <= (level_d >= RTS_THR);
      level_q    <= level_d;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= rx_shift_q;
  end

  assign txd        = txd_q;
  assign rts        = rts_q;
  assign fifo_level = level_q;
  assign frame_err  = rx_ferr_q;

endmodule

// File: tb/tb_dce_loopback_fifo.sv
// Scoreboard bench for dce_loopback_fifo: expected echoes are queued as characters are sent,
// a txd monitor decodes each frame and compares against the queue head.
module tb_dce_loopback_fifo;
  localparam int DB = 8;
  localparam int SB = 1;
  localparam int D = 16;
  localparam int DEPTH = 4;
  localparam int MARGIN = 1;
`ifdef DCE_LOOPBACK_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int FRAME = (1 + DB + P + SB) * D;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic cts = 1'b1;
  logic rxd = 1'b1;
  logic upcase_en = 1'b0;
  logic rts, txd, frame_err, overrun_err;
  logic [$clog2(DEPTH):0] fifo_level;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int frames = 0;
  int ferr_hi = 0, ferr_pulses = 0, ovr_hi = 0, ovr_pulses = 0;
  logic ferr_prev = 1'b0, ovr_prev = 1'b0;
  logic rst_seen = 1'b0;
  logic [7:0] exp_q[$];
  int start_cyc[$];

  dce_loopback_fifo #(
    .DATA_BITS(DB), .STOP_BITS(SB), .DIVISOR(D), .FIFO_DEPTH(DEPTH), .RTS_MARGIN(MARGIN)
  ) dut (
    .clock(clock), .reset_n(reset_n), .cts(cts), .rxd(rxd), .upcase_en(upcase_en),
    .rts(rts), .txd(txd), .fifo_level(fifo_level), .frame_err(frame_err), .overrun_err(overrun_err)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;
  always @(negedge reset_n) rst_seen = 1'b1;

  always @(negedge clock) begin
    if (frame_err) ferr_hi++;
    if (frame_err && !ferr_prev) ferr_pulses++;
    if (overrun_err) ovr_hi++;
    if (overrun_err && !ovr_prev) ovr_pulses++;
    ferr_prev = frame_err;
    ovr_prev  = overrun_err;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send_char(input logic [7:0] c, input logic stop_val);
    rxd = 1'b0;
    tick(D);
    for (int i = 0; i < DB; i++) begin
      rxd = c[i];
      tick(D);
    end
    if (P == 1) begin
      rxd = ^c;
      tick(D);
    end
    rxd = stop_val;
    tick(D);
    rxd = 1'b1;
    tick(2);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick(1);
      n++;
    end
    check(name, exp_q.size(), 0);
  endtask

  // txd monitor: samples each bit at its centre, discards frames cut by reset
  initial begin : monitor
    logic [7:0] ch;
    logic [7:0] e;
    logic ok_start, ok_stop, ok_par;
    int sc;
    forever begin
      @(negedge clock);
      if (reset_n && txd == 1'b0) begin
        rst_seen = 1'b0;
        sc = cyc;
        ch = 8'h00;
        repeat (D / 2) @(negedge clock);
        ok_start = (txd == 1'b0);
        for (int i = 0; i < DB; i++) begin
          repeat (D) @(negedge clock);
          ch[i] = txd;
        end
        ok_par = 1'b1;
        if (P == 1) begin
          repeat (D) @(negedge clock);
          ok_par = (txd == ^ch);
        end
        repeat (D) @(negedge clock);
        ok_stop = (txd == 1'b1);
        if (!rst_seen) begin
          frames++;
          start_cyc.push_back(sc);
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL echo: unexpected char 0x%02h, expected none", ch);
          end else begin
            e = exp_q.pop_front();
            if (ch !== e || !ok_start || !ok_stop || !ok_par) begin
              failures++;
              $display("FAIL echo: got 0x%02h start_ok=%0b stop_ok=%0b par_ok=%0b expected 0x%02h",
                       ch, ok_start, ok_stop, ok_par, e);
            end
          end
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin : stim
    logic [7:0] ch_list [4];
    logic [7:0] exp_list [4];
    int base, fbase;

    repeat (5) @(posedge clock);
    #1;
    check("rst_txd", int'(txd), 1);
    check("rst_rts", int'(rts), 1);
    check("rst_level", int'(fifo_level), 0);
    check("rst_frame_err", int'(frame_err), 0);
    check("rst_overrun_err", int'(overrun_err), 0);
    reset_n = 1'b1;
    check("rts_held_until_clock", int'(rts), 1);
    tick(1);
    check("rts_falls_first_clock", int'(rts), 0);

    cts = 1'b0;
    tick(4);

    // lower-case a upcased, start bit one clock after the push
    upcase_en = 1'b1;
    exp_q.push_back(8'h41);
    fork
      send_char(8'h61, 1'b1);
      begin
        int n;
        n = 0;
        while (fifo_level != 1 && n < 400) begin
          @(negedge clock);
          n++;
        end
        check("t1_level_one", int'(fifo_level), 1);
        @(negedge clock);
        check("t1_start_after_push", int'(txd), 0);
        check("t1_level_zero", int'(fifo_level), 0);
      end
    join
    wait_drain("t1_drain", 400);

    // unchanged echo with conversion off
    upcase_en = 1'b0;
    exp_q.push_back(8'h7A);
    exp_q.push_back(8'h0D);
    send_char(8'h7A, 1'b1);
    send_char(8'h0D, 1'b1);
    wait_drain("t2_drain", 400);

    // conversion range boundaries
    upcase_en = 1'b1;
    ch_list  = '{8'h60, 8'h7B, 8'h7A, 8'h61};
    exp_list = '{8'h60, 8'h7B, 8'h5A, 8'h41};
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(exp_list[i]);
      send_char(ch_list[i], 1'b1);
    end
    wait_drain("t3_drain", 400);

    // framing error then a good character
    fbase = frames;
    send_char(8'h33, 1'b0);
    tick(D);
    check("ferr_pulses", ferr_pulses, 1);
    check("ferr_one_cycle", ferr_hi, 1);
    check("ferr_level", int'(fifo_level), 0);
    check("ferr_no_echo", frames, fbase);
    exp_q.push_back(8'h55);
    send_char(8'h55, 1'b1);
    wait_drain("ferr_recover_drain", 400);

    // false start
    fbase = frames;
    rxd = 1'b0;
    tick(D / 4);
    rxd = 1'b1;
    tick(3 * D);
    check("fs_level", int'(fifo_level), 0);
    check("fs_ferr", ferr_pulses, 1);
    check("fs_ovr", ovr_pulses, 0);
    tick(FRAME);
    check("fs_no_echo", frames, fbase);

    // overrun with cts held off, then drain
    cts = 1'b1;
    tick(4);
    for (int i = 0; i < 5; i++) begin
      if (i < 4) exp_q.push_back(8'h41 + 8'(i));
      send_char(8'h41 + 8'(i), 1'b1);
      check($sformatf("ovr_level_%0d", i), int'(fifo_level), (i < 4) ? i + 1 : 4);
      check($sformatf("ovr_rts_%0d", i), int'(rts), (i >= 2) ? 1 : 0);
    end
    check("ovr_pulses", ovr_pulses, 1);
    check("ovr_one_cycle", ovr_hi, 1);
    base = start_cyc.size();
    cts = 1'b0;
    wait_drain("ovr_drain", 4 * FRAME + 200);
    check("ovr_frames", start_cyc.size() - base, 4);
    for (int k = 1; k < 4; k++) begin
      if (base + k < start_cyc.size())
        check($sformatf("b2b_gap_%0d", k), start_cyc[base + k] - start_cyc[base + k - 1], FRAME);
    end
    check("ovr_level_after", int'(fifo_level), 0);
    check("ovr_rts_after", int'(rts), 0);

    // reset mid-transmit with two queued
    cts = 1'b1;
    tick(4);
    for (int i = 0; i < 3; i++) send_char(8'h31 + 8'(i), 1'b1);
    check("rst_pre_level3", int'(fifo_level), 3);
    cts = 1'b0;
    tick(3 * D);
    check("rst_pre_level2", int'(fifo_level), 2);
    reset_n = 1'b0;
    #1;
    check("rst_mid_txd", int'(txd), 1);
    check("rst_mid_level", int'(fifo_level), 0);
    check("rst_mid_rts", int'(rts), 1);
    tick(3);
    reset_n = 1'b1;
    fbase = frames;
    tick(3 * FRAME);
    check("rst_no_echo", frames, fbase);
    check("rst_post_level", int'(fifo_level), 0);
    check("rst_post_rts", int'(rts), 0);
    check("rst_post_ferr", ferr_pulses, 1);
    check("final_queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
